// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared state codes, lamp patterns and transition rule for the tail-light sequencer/monitor
package tail_light_pkg;
  typedef enum logic [2:0] {
    ST_L1 = 3'b001,
    ST_L2 = 3'b010,
    ST_L3 = 3'b011,
    ST_R1 = 3'b100,
    ST_R2 = 3'b101,
    ST_R3 = 3'b110,
    ST_N  = 3'b111
  } state_e;
  localparam logic [5:0] PAT_N  = 6'b000000;
  localparam logic [5:0] PAT_L1 = 6'b100000;
  localparam logic [5:0] PAT_L2 = 6'b110000;
  localparam logic [5:0] PAT_L3 = 6'b111000;
  localparam logic [5:0] PAT_R1 = 6'b000100;
  localparam logic [5:0] PAT_R2 = 6'b000110;
  localparam logic [5:0] PAT_R3 = 6'b000111;
  function automatic logic legal_step(state_e cur, state_e nxt);
    return nxt == ST_N
        || (cur == ST_N  && (nxt == ST_L1 || nxt == ST_R1))
        || (cur == ST_L1 && nxt == ST_L2)
        || (cur == ST_L2 && nxt == ST_L3)
        || (cur == ST_R1 && nxt == ST_R2)
        || (cur == ST_R2 && nxt == ST_R3);
  endfunction
endpackage

// File: rtl/tail_light_monitor_if.sv
// tail_light_monitor_if: step/pattern inputs and status outputs of the tail-light monitor
interface tail_light_monitor_if #(parameter int CNT_W = 8);
  logic             step_en;
  logic [5:0]       lights;
  logic             clear;
  logic [2:0]       state_out;
  logic [1:0]       dir_seen;
  logic             seq_done;
  logic             abort;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] left_count;
  logic [CNT_W-1:0] right_count;
  modport master (
    output step_en, lights, clear,
    input  state_out, dir_seen, seq_done, abort, err, err_sticky, left_count, right_count
  );
  modport slave (
    input  step_en, lights, clear,
    output state_out, dir_seen, seq_done, abort, err, err_sticky, left_count, right_count
  );
endinterface

// File: rtl/tl_pattern_decode.sv
// tl_pattern_decode: maps a 6-bit lamp pattern to its state code and a legality flag
module tl_pattern_decode
  import tail_light_pkg::*;
(
  input  logic [5:0] lights,
  output logic       valid,
  output state_e     state
);
  always_comb begin
    state = lights == PAT_L1 ? ST_L1 :
            lights == PAT_L2 ? ST_L2 :
            lights == PAT_L3 ? ST_L3 :
            lights == PAT_R1 ? ST_R1 :
            lights == PAT_R2 ? ST_R2 :
            lights == PAT_R3 ? ST_R3 : ST_N;
    valid = lights == PAT_N || state != ST_N;
  end
endmodule

// File: rtl/tail_light_monitor.sv
// tail_light_monitor: tracks sequencer lamp state, flags illegal steps and counts completed sequences
module tail_light_monitor
  import tail_light_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic                 clock,
  input logic                 reset,
  tail_light_monitor_if.slave bus
);
  logic             dec_valid;
  state_e           dec_state;
  state_e           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic             done_q, done_d, abort_q, abort_d, err_q, err_d, sticky_q, sticky_d;
  logic [CNT_W-1:0] left_q, left_d, right_q, right_d;
  logic             ok, from_full, from_part;
  tl_pattern_decode u_dec (
    .lights(bus.lights),
    .valid (dec_valid),
    .state (dec_state)
  );
  always_comb begin
    ok        = dec_valid && legal_step(state_q, dec_state);
    from_full = state_q == ST_L3 || state_q == ST_R3;
    from_part = state_q inside {ST_L1, ST_L2, ST_R1, ST_R2};
    done_d    = bus.step_en && ok && dec_state == ST_N && from_full;
    abort_d   = bus.step_en && ok && dec_state == ST_N && from_part;
    err_d     = bus.step_en && !ok;
    state_d   = bus.step_en ? dec_state : state_q;
    dir_d     = !done_d ? dir_q : (state_q == ST_L3 ? 2'b10 : 2'b01);
    left_d    = bus.clear ? '0 :
                ((done_d && state_q == ST_L3 && left_q != '1) ? left_q + 1'b1 : left_q);
    right_d   = bus.clear ? '0 :
                ((done_d && state_q == ST_R3 && right_q != '1) ? right_q + 1'b1 : right_q);
    sticky_d  = !bus.clear && (sticky_q || err_d);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_N;
      dir_q    <= 2'b00;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end
  assign bus.state_out   = state_q;
  assign bus.dir_seen    = dir_q;
  assign bus.seq_done    = done_q;
  assign bus.abort       = abort_q;
  assign bus.err         = err_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.left_count  = left_q;
  assign bus.right_count = right_q;
endmodule

// File: tb/tb_tail_light_monitor.sv
// tb_tail_light_monitor: vector table, corner sequences and random stimulus against a lamp-position model
module tb_tail_light_monitor;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       step_en = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] lights = 6'b0;
  always #5 clock = ~clock;
  tail_light_monitor_if #(.CNT_W(8)) if8 ();
  tail_light_monitor_if #(.CNT_W(2)) if2 ();
  assign if8.step_en = step_en;
  assign if8.lights  = lights;
  assign if8.clear   = clear;
  assign if2.step_en = step_en;
  assign if2.lights  = lights;
  assign if2.clear   = clear;
  tail_light_monitor #(.CNT_W(8)) dut8 (.clock(clock), .reset(reset), .bus(if8.slave));
  tail_light_monitor #(.CNT_W(2)) dut2 (.clock(clock), .reset(reset), .bus(if2.slave));
  typedef struct {
    bit         en;
    logic [5:0] l;
    int         st, dn, ab, er, dir, lc, sk;
  } vec_t;
  vec_t       tbl[14];
  logic [5:0] pats[7] = '{6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b000100, 6'b000110, 6'b000111};
  int         posv[7] = '{0, 1, 2, 3, -1, -2, -3};
  int         m_pos, m_dir, m_done, m_abort, m_err, m_sticky, m_lc, m_rc, m_lc2, m_rc2;
  int         checks = 0;
  int         errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int code_of(int p);
    return p == 0 ? 7 : (p > 0 ? p : 3 - p);
  endfunction
  function automatic int idx_of(int p);
    return p >= 0 ? p : 3 - p;
  endfunction
  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_done = 0; m_abort = 0; m_err = 0;
    m_sticky = 0; m_lc = 0; m_rc = 0; m_lc2 = 0; m_rc2 = 0;
  endtask
  task automatic model_step(bit en, logic [5:0] l, bit clr);
    int np;
    bit valid, legal;
    m_done = 0; m_abort = 0; m_err = 0;
    if (en) begin
      valid = 0;
      np = 0;
      for (int i = 0; i < 7; i++) if (pats[i] == l) begin valid = 1; np = posv[i]; end
      legal = valid && (np == 0 || (m_pos == 0 ? (np == 1 || np == -1) : np == m_pos + (m_pos > 0 ? 1 : -1)));
      m_err = !legal;
      if (legal && np == 0 && m_pos != 0) begin
        if (m_pos == 3 || m_pos == -3) m_done = 1;
        else m_abort = 1;
      end
      if (m_done) begin
        m_dir = m_pos > 0 ? 2 : 1;
        if (!clr) begin
          if (m_pos > 0) begin
            m_lc = m_lc < 255 ? m_lc + 1 : 255;
            m_lc2 = m_lc2 < 3 ? m_lc2 + 1 : 3;
          end else begin
            m_rc = m_rc < 255 ? m_rc + 1 : 255;
            m_rc2 = m_rc2 < 3 ? m_rc2 + 1 : 3;
          end
        end
      end
      m_pos = np;
    end
    if (m_err) m_sticky = 1;
    if (clr) begin
      m_lc = 0; m_rc = 0; m_lc2 = 0; m_rc2 = 0; m_sticky = 0;
    end
  endtask
  task automatic check_all();
    chk("state8", if8.state_out, code_of(m_pos));
    chk("dir8", if8.dir_seen, m_dir);
    chk("done8", if8.seq_done, m_done);
    chk("abort8", if8.abort, m_abort);
    chk("err8", if8.err, m_err);
    chk("sticky8", if8.err_sticky, m_sticky);
    chk("lc8", if8.left_count, m_lc);
    chk("rc8", if8.right_count, m_rc);
    chk("state2", if2.state_out, code_of(m_pos));
    chk("dir2", if2.dir_seen, m_dir);
    chk("done2", if2.seq_done, m_done);
    chk("abort2", if2.abort, m_abort);
    chk("err2", if2.err, m_err);
    chk("sticky2", if2.err_sticky, m_sticky);
    chk("lc2", if2.left_count, m_lc2);
    chk("rc2", if2.right_count, m_rc2);
  endtask
  task automatic step(bit en, logic [5:0] l, bit clr);
    step_en = en;
    lights = l;
    clear = clr;
    @(posedge clock);
    model_step(en, l, clr);
    #1;
    check_all();
    step_en = 1'b0;
    clear = 1'b0;
  endtask
  initial begin
    int r;
    logic [5:0] l;
    bit en, clr;
    tbl[0]  = '{1, 6'b000000, 7, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 6'b100000, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 6'b110000, 2, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 6'b111000, 3, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 6'b000000, 7, 1, 0, 0, 2, 1, 0};
    tbl[5]  = '{1, 6'b000100, 4, 0, 0, 0, 2, 1, 0};
    tbl[6]  = '{1, 6'b000110, 5, 0, 0, 0, 2, 1, 0};
    tbl[7]  = '{1, 6'b000000, 7, 0, 1, 0, 2, 1, 0};
    tbl[8]  = '{1, 6'b101000, 7, 0, 0, 1, 2, 1, 1};
    tbl[9]  = '{1, 6'b000000, 7, 0, 0, 0, 2, 1, 1};
    tbl[10] = '{1, 6'b100000, 1, 0, 0, 0, 2, 1, 1};
    tbl[11] = '{1, 6'b111000, 3, 0, 0, 1, 2, 1, 1};
    tbl[12] = '{1, 6'b000000, 7, 1, 0, 0, 2, 2, 1};
    tbl[13] = '{0, 6'b110000, 7, 0, 0, 0, 2, 2, 1};
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].l, 1'b0);
      chk("tbl_state", if8.state_out, tbl[i].st);
      chk("tbl_done", if8.seq_done, tbl[i].dn);
      chk("tbl_abort", if8.abort, tbl[i].ab);
      chk("tbl_err", if8.err, tbl[i].er);
      chk("tbl_dir", if8.dir_seen, tbl[i].dir);
      chk("tbl_lc", if8.left_count, tbl[i].lc);
      chk("tbl_sticky", if8.err_sticky, tbl[i].sk);
    end
    repeat (4) begin
      step(1, 6'b100000, 0);
      step(1, 6'b110000, 0);
      step(1, 6'b111000, 0);
      step(1, 6'b000000, 0);
    end
    chk("sat_lc2", if2.left_count, 3);
    chk("lc8_6", if8.left_count, 6);
    step(1, 6'b100000, 0);
    step(1, 6'b110000, 0);
    step(1, 6'b111000, 0);
    step(1, 6'b000000, 1);
    chk("clr_lc2", if2.left_count, 0);
    chk("clr_lc8", if8.left_count, 0);
    chk("clr_sticky", if8.err_sticky, 0);
    chk("clr_done", if8.seq_done, 1);
    step(1, 6'b100000, 0);
    step(1, 6'b110000, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_state", if8.state_out, 7);
    chk("rst_dir", if8.dir_seen, 0);
    @(negedge clock);
    reset = 1'b1;
    step(1, 6'b000100, 0);
    chk("post_r1_state", if8.state_out, 4);
    chk("post_r1_err", if8.err, 0);
    step(1, 6'b000000, 0);
    step(1, 6'b111000, 0);
    chk("post_l3_err", if8.err, 1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      if (r < 50) begin
        if (m_pos == 0) l = $urandom_range(1) ? pats[1] : pats[4];
        else if (m_pos == 3 || m_pos == -3) l = pats[0];
        else l = pats[idx_of(m_pos + (m_pos > 0 ? 1 : -1))];
      end else if (r < 85) l = pats[$urandom_range(6)];
      else l = 6'($urandom);
      en = $urandom_range(9) < 7;
      clr = $urandom_range(99) < 3;
      step(en, l, clr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
